// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder built from per-bit full-adder cells, with a
// one-cycle registered copy of the result. Optional checker: FULL_ADDER_CHECK_EN.
module full_adder #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   input  logic             in_valid,
   output logic [WIDTH-1:0] s_q,
   output logic             cout_q,
   output logic             out_valid,
   output logic             err
);

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s_reg;
   logic             cout_reg;
   logic             valid_reg;

   assign c[0] = cin;

   // One explicit cell per bit so the carry ripples through gate logic
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic p;
         assign p         = a[gi] ^ b[gi];
         assign s[gi]     = p ^ c[gi];
         assign c[gi + 1] = (a[gi] & b[gi]) | (c[gi] & p);
      end
   endgenerate

   assign cout = c[WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_reg     <= '0;
         cout_reg  <= 1'b0;
         valid_reg <= 1'b0;
      end else begin
         valid_reg <= in_valid;
         if (in_valid) begin
            s_reg    <= s;
            cout_reg <= cout;
         end
      end
   end

   assign s_q       = s_reg;
   assign cout_q    = cout_reg;
   assign out_valid = valid_reg;

`ifdef FULL_ADDER_CHECK_EN
   logic [WIDTH:0] ref_sum;
   logic           err_reg;

   // Behavioural reference, independent of the gate-level chain above
   assign ref_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_reg <= 1'b0;
      end else if (in_valid && (ref_sum != {cout, s})) begin
         err_reg <= 1'b1;
      end
   end

   assign err = err_reg;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Directed + random bench for full_adder: a WIDTH=1 truth-table instance and a
// WIDTH=8 instance whose registered stage is checked through a scoreboard queue.
module tb_full_adder;

   logic       clk = 1'b0;
   logic       rst;

   logic       a1, b1, cin1, iv1;
   logic       s1, cout1, s_q1, cout_q1, ov1, err1;

   logic [7:0] a8, b8, s8, s_q8;
   logic       cin8, iv8, cout8, cout_q8, ov8, err8;

   int         checks   = 0;
   int         failures = 0;
   logic [8:0] exp_q[$];
   logic [7:0] held_s = 8'h00;
   logic       held_c = 1'b0;

   always #5 clk = ~clk;

   full_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .s(s1), .cout(cout1),
      .in_valid(iv1), .s_q(s_q1), .cout_q(cout_q1), .out_valid(ov1), .err(err1)
   );

   full_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .s(s8), .cout(cout8),
      .in_valid(iv8), .s_q(s_q8), .cout_q(cout_q8), .out_valid(ov8), .err(err8)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One clock cycle on the 8-bit instance; captures are scoreboarded
   task automatic step(input logic iv, input logic [7:0] ta, input logic [7:0] tb_v, input logic tc);
      logic [8:0] e;
      @(negedge clk);
      iv8 = iv; a8 = ta; b8 = tb_v; cin8 = tc;
      if (iv) exp_q.push_back({1'b0, ta} + {1'b0, tb_v} + {8'h00, tc});
      @(posedge clk);
      #1;
      if (iv) begin
         if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
         end else begin
            e = exp_q.pop_front();
            held_s = e[7:0];
            held_c = e[8];
            check("s_q", {24'h0, s_q8}, {24'h0, e[7:0]});
            check("cout_q", {31'h0, cout_q8}, {31'h0, e[8]});
            check("out_valid_hi", {31'h0, ov8}, 32'd1);
         end
      end else begin
         check("out_valid_lo", {31'h0, ov8}, 32'd0);
         check("s_q_hold", {24'h0, s_q8}, {24'h0, held_s});
         check("cout_q_hold", {31'h0, cout_q8}, {31'h0, held_c});
      end
   endtask

   initial begin
      logic [1:0] r1;
      logic [8:0] r8;
      rst = 1'b1;
      a1 = 0; b1 = 0; cin1 = 0; iv1 = 0;
      a8 = 0; b8 = 0; cin8 = 0; iv8 = 0;
      #1;
      check("rst_s_q", {24'h0, s_q8}, 32'd0);
      check("rst_cout_q", {31'h0, cout_q8}, 32'd0);
      check("rst_out_valid", {31'h0, ov8}, 32'd0);
      check("rst_err", {31'h0, err8}, 32'd0);

      // WIDTH=1 truth table, combinational while still in reset
      for (int i = 0; i < 8; i++) begin
         a1 = i[2]; b1 = i[1]; cin1 = i[0];
         r1 = {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
         #5;
         check($sformatf("tt%0d_s", i), {31'h0, s1}, {31'h0, r1[0]});
         check($sformatf("tt%0d_cout", i), {31'h0, cout1}, {31'h0, r1[1]});
      end
      a1 = 1; b1 = 1; cin1 = 0; #5;
      check("tt110_s", {31'h0, s1}, 32'd0);
      check("tt110_cout", {31'h0, cout1}, 32'd1);

      a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1; #5;
      check("ripple_s", {24'h0, s8}, 32'h00);
      check("ripple_cout", {31'h0, cout8}, 32'd1);
      a8 = 8'h5A; b8 = 8'h25; cin8 = 1'b0; #5;
      check("5a25_s", {24'h0, s8}, 32'h7F);
      check("5a25_cout", {31'h0, cout8}, 32'd0);

      // in_valid high across an edge while rst is still asserted: no capture
      @(negedge clk);
      iv8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
      @(posedge clk);
      #1;
      check("rst_edge_ov", {31'h0, ov8}, 32'd0);
      check("rst_edge_s_q", {24'h0, s_q8}, 32'd0);
      rst = 1'b0;
      exp_q.push_back(9'h003);
      @(posedge clk);
      #1;
      r8 = exp_q.pop_front();
      check("post_rst_s_q", {24'h0, s_q8}, {24'h0, r8[7:0]});
      check("post_rst_ov", {31'h0, ov8}, 32'd1);
      held_s = r8[7:0];
      held_c = r8[8];

      step(1'b1, 8'h80, 8'h80, 1'b0);
      step(1'b0, 8'h11, 8'h22, 1'b1);
      step(1'b1, 8'h5A, 8'h25, 1'b0);

      // Async reset between edges
      @(negedge clk);
      iv8 = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("async_s_q", {24'h0, s_q8}, 32'd0);
      check("async_cout_q", {31'h0, cout_q8}, 32'd0);
      check("async_ov", {31'h0, ov8}, 32'd0);
      check("async_err", {31'h0, err8}, 32'd0);
      a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1;
      #1;
      check("rst_comb_s", {24'h0, s8}, 32'h00);
      check("rst_comb_cout", {31'h0, cout8}, 32'd1);
      held_s = 8'h00;
      held_c = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 8'h33, 8'h44, 1'b0);

      // Back-to-back random traffic with occasional idle cycles
      for (int i = 0; i < 60; i++) begin
         step(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
      end

`ifdef FULL_ADDER_CHECK_EN
      for (int i = 0; i < 1000; i++) begin
         step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      end
      check("chk_err_clean", {31'h0, err8}, 32'd0);
      @(negedge clk);
      iv8 = 1'b1; a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0;
      force dut8.s = 8'h06;
      @(posedge clk);
      #1;
      release dut8.s;
      iv8 = 1'b0;
      check("chk_err_set", {31'h0, err8}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("chk_err_sticky", {31'h0, err8}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("chk_err_cleared", {31'h0, err8}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
`endif

      check("scoreboard_drained", exp_q.size(), 32'd0);
      check("final_err", {31'h0, err8}, 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
